wb_tgt_mem: RTL and testbench

- Pipelined Wishbone target: a small word-addressed memory with byte selects, per-word write-data tags and a fixed, parameterized response latency.
- It is the responder end of the initiator-to-target interface used across the crossbar. It is the standard endpoint behind crossbar target ports, in simulation and formal runs.
- After reset it clears its memory, stalling until the clear completes. It then serves back-to-back pipelined reads and writes, with one response per accepted request.

---
 rtl/wb_tgt_mem.sv | 170 +++++++++++++++++
 tb/tb_wb_tgt_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target memory: byte-selectable words with a per-word tag, cleared after every reset.
// Responses appear a fixed LATENCY cycles after acceptance; dropping cyc flushes in-flight responses.
module wb_tgt_mem #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int TGA_WIDTH = 1,
    parameter int TGC_WIDTH = 1,
    parameter int TGD_WIDTH = 1,
    parameter int MEM_AW    = 4,
    parameter int LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 itr_cyc_i,
    input  logic                 itr_stb_i,
    input  logic                 itr_we_i,
    input  logic                 itr_lock_i,
    input  logic [SEL_WIDTH-1:0] itr_sel_i,
    input  logic [ADR_WIDTH-1:0] itr_adr_i,
    input  logic [DAT_WIDTH-1:0] itr_dat_i,
    input  logic [TGA_WIDTH-1:0] itr_tga_i,
    input  logic [TGC_WIDTH-1:0] itr_tgc_i,
    input  logic [TGD_WIDTH-1:0] itr_tgd_i,
    output logic                 itr_ack_o,
    output logic                 itr_err_o,
    output logic                 itr_rty_o,
    output logic                 itr_stall_o,
    output logic [DAT_WIDTH-1:0] itr_dat_o,
    output logic [TGD_WIDTH-1:0] itr_tgd_o
);

    localparam int DEPTH  = 1 << MEM_AW;
    localparam int LANE_W = DAT_WIDTH / SEL_WIDTH;
    localparam int LAST   = LATENCY - 1;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   ptr_q, ptr_d;
    logic                stall_q, stall_d;
    logic                clr_we;

    logic [DAT_WIDTH-1:0] mem_q [DEPTH];
    logic [TGD_WIDTH-1:0] tag_q [DEPTH];

    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   err_q;
    logic [DAT_WIDTH-1:0] pdat_q [LATENCY];
    logic [TGD_WIDTH-1:0] ptgd_q [LATENCY];

    logic              req;
    logic              oor;
    logic              wr_en;
    logic              rd_hit;
    logic [MEM_AW-1:0] idx;
    logic              unused_ok;

    assign unused_ok = ^{itr_lock_i, itr_tga_i, itr_tgc_i};

    assign req    = itr_cyc_i & itr_stb_i & ~stall_q;
    assign oor    = |(itr_adr_i >> MEM_AW);
    assign idx    = itr_adr_i[MEM_AW-1:0];
    assign wr_en  = req & itr_we_i & ~oor & ~sync_rst_i;
    assign rd_hit = ~itr_we_i & ~oor;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        clr_we  = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == {MEM_AW{1'b1}}) begin
                    state_d = S_READY;
                    stall_d = 1'b0;
                end
            end
            S_READY: begin
                stall_d = 1'b0;
            end
            default: begin
                state_d = S_INIT;
                stall_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            stall_q <= 1'b1;
        end else if (sync_rst_i) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            stall_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
        end
    end

    // Storage has no reset of its own; the INIT sweep clears it.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[ptr_q] <= '0;
            tag_q[ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (itr_sel_i[i]) begin
                    mem_q[idx][i*LANE_W +: LANE_W] <= itr_dat_i[i*LANE_W +: LANE_W];
                end
            end
            if (|itr_sel_i) begin
                tag_q[idx] <= itr_tgd_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pdat_q[i] <= '0;
                ptgd_q[i] <= '0;
            end
        end else if (sync_rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pdat_q[i] <= '0;
                ptgd_q[i] <= '0;
            end
        end else begin
            if (!itr_cyc_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= req;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
            err_q[0]  <= oor;
            pdat_q[0] <= rd_hit ? mem_q[idx] : '0;
            ptgd_q[0] <= rd_hit ? tag_q[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                err_q[i]  <= err_q[i-1];
                pdat_q[i] <= pdat_q[i-1];
                ptgd_q[i] <= ptgd_q[i-1];
            end
        end
    end

    assign itr_ack_o   = vld_q[LAST] & ~err_q[LAST] & itr_cyc_i;
    assign itr_err_o   = vld_q[LAST] &  err_q[LAST] & itr_cyc_i;
    assign itr_rty_o   = 1'b0;
    assign itr_stall_o = stall_q;
    assign itr_dat_o   = (itr_ack_o | itr_err_o) ? pdat_q[LAST] : '0;
    assign itr_tgd_o   = (itr_ack_o | itr_err_o) ? ptgd_q[LAST] : '0;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Randomised bench for wb_tgt_mem: a driver feeds requests and a word-array model, a monitor scores responses.
module tb_wb_tgt_mem;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        async_rst, sync_rst;
    logic        cyc, stb, we, lock;
    logic [1:0]  sel;
    logic [15:0] adr, wdat;
    logic [0:0]  tga, tgc, wtgd;
    logic        ack, err, rty, stall;
    logic [15:0] rdat;
    logic [0:0]  rtgd;

    always #5 clk = ~clk;

    wb_tgt_mem #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2), .TGA_WIDTH(1), .TGC_WIDTH(1),
        .TGD_WIDTH(1), .MEM_AW(4), .LATENCY(L)
    ) dut (
        .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
        .itr_cyc_i(cyc), .itr_stb_i(stb), .itr_we_i(we), .itr_lock_i(lock),
        .itr_sel_i(sel), .itr_adr_i(adr), .itr_dat_i(wdat), .itr_tga_i(tga),
        .itr_tgc_i(tgc), .itr_tgd_i(wtgd),
        .itr_ack_o(ack), .itr_err_o(err), .itr_rty_o(rty), .itr_stall_o(stall),
        .itr_dat_o(rdat), .itr_tgd_o(rtgd)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] dat;
        logic        tgd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_dat [16];
    logic        m_tgd [16];
    int          cyc_cnt = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
            chk_cnt++;
            $display("FAIL missing_resp: no response by cycle %0d, expected at %0d", cyc_cnt, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (ack || err) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_resp: ack=%0b err=%0b with nothing outstanding (cycle %0d)",
                         ack, err, cyc_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_cycle", cyc_cnt, e.cyc);
                chk("ack_err", {ack, err}, {~e.err, e.err});
                chk("rd_dat", rdat, e.dat);
                chk("rd_tgd", rtgd, e.tgd);
            end
        end
    end

    // Called at posedge+1; request is presented until the edge that accepts it.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] s, input logic t);
        exp_t e;
        int   n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; wtgd = t;
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (stall) begin
            chk_cnt++;
            $display("FAIL stall_timeout: stall stuck at 1 (cycle %0d)", cyc_cnt);
        end else begin
            e.cyc = cyc_cnt + L;
            e.err = (a >= 16'd16);
            e.dat = '0;
            e.tgd = 1'b0;
            if (!e.err) begin
                if (w) begin
                    if (s[0]) m_dat[a[3:0]][7:0]  = d[7:0];
                    if (s[1]) m_dat[a[3:0]][15:8] = d[15:8];
                    if (s != 2'b00) m_tgd[a[3:0]] = t;
                end else begin
                    e.dat = m_dat[a[3:0]];
                    e.tgd = m_tgd[a[3:0]];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Dropping cyc at the coming edge kills everything not yet shown in a cyc-high cycle.
    task automatic abort_cycle();
        cyc = 1'b0; stb = 1'b0;
        while (sb.size() > 0 && sb[$].cyc >= cyc_cnt) void'(sb.pop_back());
        @(posedge clk); #1;
        cyc = 1'b1;
    endtask

    task automatic count_stall(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
        chk(name, n, 16);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst = 1'b1; sync_rst = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0; sel = '0; adr = '0; wdat = '0;
        tga = '0; tgc = '0; wtgd = '0;
        for (int i = 0; i < 16; i++) begin m_dat[i] = '0; m_tgd[i] = 1'b0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 1);
        chk("rst_ack_err_rty", {ack, err, rty}, 0);
        chk("rst_dat_tgd", {rdat, rtgd}, 0);
        @(posedge clk); #1;
        async_rst = 1'b0;
        count_stall("init_stall_cycles");

        // Directed scenarios
        do_req(1'b1, 16'h0003, 16'hBEEF, 2'b11, 1'b1);
        do_req(1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0);
        idle(3);
        do_req(1'b1, 16'h0005, 16'h12AB, 2'b01, 1'b0);
        do_req(1'b0, 16'h0005, 16'h0000, 2'b00, 1'b0);
        do_req(1'b0, 16'h0006, 16'h0000, 2'b00, 1'b0);
        idle(3);
        do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0);
        do_req(1'b1, 16'h0010, 16'h5555, 2'b11, 1'b1);
        do_req(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) do_req(1'b0, 16'(i), 16'h0, 2'b00, 1'b0);
        idle(3);
        do_req(1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0);
        abort_cycle();
        idle(4);
        do_req(1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0);
        idle(4);

        // Random traffic with gaps and aborts
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) idle(1);
            else if (r == 1) abort_cycle();
            else do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 19)),
                        16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(L + 2);

        // Synchronous reset re-clears memory and re-runs the stall window
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin m_dat[i] = '0; m_tgd[i] = 1'b0; end
        count_stall("sync_rst_stall_cycles");
        for (int i = 0; i < 16; i++) do_req(1'b0, 16'(i), 16'h0, 2'b00, 1'b0);
        idle(L + 3);

        chk("drained", sb.size(), 0);
        chk("rty_tied", rty, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
